aoi21_bist: RTL and testbench

Built-in self-test driver/checker for the AOI21X1 cell and for any three-input cell computing Y = ~((A&B)|C).
- Drives every A/B/C input combination into a cell-under-test (CUT), waits for the outputs to settle, then samples Y.
- Compares each sample against the golden function, counts mismatches and compresses all responses into a MISR signature.
- Sits beside library cell instances in characterisation and test chips; run status is read back by the chip test controller.

---
 rtl/aoi21_bist_pkg.sv | 20 ++
 rtl/bist_misr.sv | 31 +++
 rtl/aoi21_bist.sv | 149 ++++++++++++++
 tb/tb_aoi21_bist.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/aoi21_bist_pkg.sv
// Shared types and constants for the AOI21 self-test block.
package aoi21_bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        SAMPLE  = 2'd2,
        DONE_ST = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_MISR_POLY = 16'h1021;

    // Bit i holds the golden Y = ~((A&B)|C) for vector {A,B,C} = i.
    localparam logic [7:0] EXP_TABLE = 8'b0001_0101;

    function automatic logic expected_y(input logic [2:0] vec);
        return EXP_TABLE[vec];
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Galois MISR that compresses one response bit per enabled cycle.
module bist_misr
    import aoi21_bist_pkg::*;
#(
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEFAULT_MISR_POLY)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              init,
    input  logic              en,
    input  logic              din,
    output logic [MISR_W-1:0] sig
);

    // Signature register: seed to all-ones, then shift with feedback and fold din into bit 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sig <= '1;
        end else if (init) begin
            sig <= '1;
        end else if (en) begin
            sig <= {sig[MISR_W-2:0], 1'b0}
                 ^ (sig[MISR_W-1] ? MISR_POLY : {MISR_W{1'b0}})
                 ^ {{(MISR_W-1){1'b0}}, din};
        end else begin
            sig <= sig;
        end
    end

endmodule

// File: rtl/aoi21_bist.sv
// Self-test driver/checker: sweeps all A/B/C vectors into an AOI21-type cell,
// counts mismatches against the golden function and compresses Y into a MISR.
module aoi21_bist
    import aoi21_bist_pkg::*;
#(
    parameter int                NUM_PASSES    = 4,
    parameter int                SETTLE_CYCLES = 2,
    parameter int                MISR_W        = 16,
    parameter logic [MISR_W-1:0] MISR_POLY     = MISR_W'(DEFAULT_MISR_POLY)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              A_O,
    output logic              B_O,
    output logic              C_O,
    input  logic              Y_I,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [7:0]        ERR_CNT,
    output logic [2:0]        FAIL_VEC,
    output logic [MISR_W-1:0] SIGNATURE
);

    localparam int             CNT_W         = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]     LAST_PASS     = 8'(NUM_PASSES - 1);

    state_t           r_state;
    logic [2:0]       r_vec;
    logic [7:0]       r_pass;
    logic [CNT_W-1:0] r_settle_cnt;
    logic             r_first_fail_seen;

    logic             w_mismatch;
    logic [7:0]       w_err_next;
    logic             w_last;
    logic             w_start_ok;

    assign w_last     = (r_vec == 3'd7) && (r_pass == LAST_PASS);
    assign w_start_ok = START && ((r_state == IDLE) || (r_state == DONE_ST));

    // Mismatch detect; an unknown Y falls into the else branch and counts as a miss.
    always_comb begin
        w_mismatch = 1'b1;
        if (Y_I == expected_y(r_vec)) begin
            w_mismatch = 1'b0;
        end else begin
            w_mismatch = 1'b1;
        end
    end

    // Saturating error count for the current sample.
    always_comb begin
        w_err_next = ERR_CNT;
        if (w_mismatch && (ERR_CNT != 8'hFF)) begin
            w_err_next = ERR_CNT + 8'd1;
        end else begin
            w_err_next = ERR_CNT;
        end
    end

    // Run sequencer: vector drive, settle timing, compare and status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state           <= IDLE;
            r_vec             <= 3'd0;
            r_pass            <= 8'd0;
            r_settle_cnt      <= {CNT_W{1'b0}};
            r_first_fail_seen <= 1'b0;
            {A_O, B_O, C_O}   <= 3'd0;
            BUSY              <= 1'b0;
            DONE              <= 1'b0;
            PASS              <= 1'b0;
            ERR_CNT           <= 8'd0;
            FAIL_VEC          <= 3'd0;
        end else begin
            case (r_state)
                IDLE, DONE_ST: begin
                    if (START) begin
                        r_state           <= SETTLE;
                        r_vec             <= 3'd0;
                        r_pass            <= 8'd0;
                        r_settle_cnt      <= SETTLE_RELOAD;
                        r_first_fail_seen <= 1'b0;
                        {A_O, B_O, C_O}   <= 3'd0;
                        BUSY              <= 1'b1;
                        DONE              <= 1'b0;
                        PASS              <= 1'b0;
                        ERR_CNT           <= 8'd0;
                        FAIL_VEC          <= 3'd0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt == {CNT_W{1'b0}}) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    ERR_CNT <= w_err_next;
                    if (w_mismatch && !r_first_fail_seen) begin
                        FAIL_VEC          <= r_vec;
                        r_first_fail_seen <= 1'b1;
                    end else begin
                        r_first_fail_seen <= r_first_fail_seen;
                    end
                    if (w_last) begin
                        // Last vector stays on the CUT pins while DONE is held.
                        r_state <= DONE_ST;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                        PASS    <= (w_err_next == 8'd0);
                    end else begin
                        r_state         <= SETTLE;
                        r_vec           <= r_vec + 3'd1;
                        {A_O, B_O, C_O} <= r_vec + 3'd1;
                        r_settle_cnt    <= SETTLE_RELOAD;
                        if (r_vec == 3'd7) begin
                            r_pass <= r_pass + 8'd1;
                        end else begin
                            r_pass <= r_pass;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    bist_misr #(
        .MISR_W    (MISR_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .CLK  (CLK),
        .RST  (RST),
        .init (w_start_ok),
        .en   (r_state == SAMPLE),
        .din  (Y_I),
        .sig  (SIGNATURE)
    );

endmodule

// File: tb/tb_aoi21_bist.sv
// Scoreboard bench for aoi21_bist: three instances (default, 40 passes, 1 settle cycle).
`timescale 1ns/1ps
module tb_aoi21_bist;

    typedef struct {
        int          id;
        logic [7:0]  err;
        logic [2:0]  fv;
        logic        pass;
        logic [15:0] sig;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   mode  = 0;

    logic        clk = 1'b0;
    logic [2:0]  rst_v = 3'b000;
    logic [2:0]  start_v = 3'b000;
    logic [2:0]  a_v, b_v, c_v, y_v, busy_v, done_v, pass_v;
    logic [7:0]  err_v [3];
    logic [2:0]  fail_v [3];
    logic [15:0] sig_v [3];
    logic        glitch_ph = 1'b0;
    logic [2:0]  done_prev = 3'b000;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic aoi(input logic a, input logic b, input logic c);
        return ~((a & b) | c);
    endfunction

    // 0 good cell, 1 stuck-at-0, 2 stuck-at-1, 3 inverted output
    function automatic logic ymodel(input int m, input logic a, input logic b, input logic c);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~aoi(a, b, c);
            default: return aoi(a, b, c);
        endcase
    endfunction

    function automatic logic [15:0] misr_model(input int m, input int passes);
        logic [15:0] s;
        logic [2:0]  v;
        logic        y;
        s = 16'hFFFF;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < 8; k++) begin
                v = 3'(k);
                y = ymodel(m, v[2], v[1], v[0]);
                s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, y};
            end
        end
        return s;
    endfunction

    always_comb begin
        y_v    = 3'b000;
        y_v[0] = ymodel(mode, a_v[0], b_v[0], c_v[0]);
        y_v[1] = ~aoi(a_v[1], b_v[1], c_v[1]);
        y_v[2] = aoi(a_v[2], b_v[2], c_v[2]) ^ (glitch_ph & busy_v[2]);
    end

    // Glitch lands in the first cycle of each held vector, which is never sampled.
    always @(posedge clk) begin
        if (start_v[2] && !busy_v[2]) glitch_ph <= 1'b1;
        else                          glitch_ph <= ~glitch_ph;
    end

    aoi21_bist u_dut0 (
        .CLK(clk), .RST(rst_v[0]), .START(start_v[0]),
        .A_O(a_v[0]), .B_O(b_v[0]), .C_O(c_v[0]), .Y_I(y_v[0]),
        .BUSY(busy_v[0]), .DONE(done_v[0]), .PASS(pass_v[0]),
        .ERR_CNT(err_v[0]), .FAIL_VEC(fail_v[0]), .SIGNATURE(sig_v[0])
    );

    aoi21_bist #(.NUM_PASSES(40)) u_dut1 (
        .CLK(clk), .RST(rst_v[1]), .START(start_v[1]),
        .A_O(a_v[1]), .B_O(b_v[1]), .C_O(c_v[1]), .Y_I(y_v[1]),
        .BUSY(busy_v[1]), .DONE(done_v[1]), .PASS(pass_v[1]),
        .ERR_CNT(err_v[1]), .FAIL_VEC(fail_v[1]), .SIGNATURE(sig_v[1])
    );

    aoi21_bist #(.SETTLE_CYCLES(1)) u_dut2 (
        .CLK(clk), .RST(rst_v[2]), .START(start_v[2]),
        .A_O(a_v[2]), .B_O(b_v[2]), .C_O(c_v[2]), .Y_I(y_v[2]),
        .BUSY(busy_v[2]), .DONE(done_v[2]), .PASS(pass_v[2]),
        .ERR_CNT(err_v[2]), .FAIL_VEC(fail_v[2]), .SIGNATURE(sig_v[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Monitor: on each DONE rising edge pop the scoreboard and compare the result.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (done_v[i] && !done_prev[i]) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("dut_id",    32'(i),            32'(e.id));
                    check("err_cnt",   32'(err_v[i]),     32'(e.err));
                    check("fail_vec",  32'(fail_v[i]),    32'(e.fv));
                    check("pass",      32'(pass_v[i]),    32'(e.pass));
                    check("signature", 32'(sig_v[i]),     32'(e.sig));
                    check("latency",   32'(cyc - e.start_cyc), 32'(e.lat));
                    check("hold_vec7", 32'({a_v[i], b_v[i], c_v[i]}), 32'd7);
                end
            end
        end
        done_prev <= done_v;
    end

    task automatic run(input int id, input int m, input logic [7:0] err, input logic [2:0] fv,
                       input logic p, input int passes, input int lat, input int dup_at);
        exp_t e;
        int   n;
        mode = m;
        @(negedge clk);
        e.id = id; e.err = err; e.fv = fv; e.pass = p;
        e.sig = misr_model((id == 1) ? 3 : m, passes);
        e.lat = lat; e.start_cyc = cyc;
        sb.push_back(e);
        start_v[id] = 1'b1;
        @(negedge clk);
        start_v[id] = 1'b0;
        check("busy_after_start", 32'(busy_v[id]), 32'd1);
        check("done_drop",        32'(done_v[id]), 32'd0);
        n = 1;
        while (!done_v[id] && n < lat + 50) begin
            start_v[id] = (n == dup_at);
            @(negedge clk);
            n++;
        end
        start_v[id] = 1'b0;
        if (!done_v[id]) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: dut %0d got no DONE, expected at %0d", id, lat);
            summary();
        end
        @(negedge clk);
        check("busy_after_done", 32'(busy_v[id]), 32'd0);
    endtask

    task automatic check_reset0(input string tag);
        check({tag, "_abc"},  32'({a_v[0], b_v[0], c_v[0]}), 32'd0);
        check({tag, "_busy"}, 32'(busy_v[0]), 32'd0);
        check({tag, "_done"}, 32'(done_v[0]), 32'd0);
        check({tag, "_pass"}, 32'(pass_v[0]), 32'd0);
        check({tag, "_err"},  32'(err_v[0]),  32'd0);
        check({tag, "_fvec"}, 32'(fail_v[0]), 32'd0);
        check({tag, "_sig"},  32'(sig_v[0]),  32'h0000_FFFF);
    endtask

    initial begin
        rst_v = 3'b111;
        repeat (3) @(negedge clk);
        check_reset0("rst");
        check("rst_sig1", 32'(sig_v[1]), 32'h0000_FFFF);
        rst_v = 3'b000;

        run(0, 0, 8'd0,  3'd0, 1'b1, 4, 97, 40);   // good cell, START mid-run ignored
        run(0, 1, 8'd12, 3'd0, 1'b0, 4, 97, 0);    // stuck-at-0
        run(0, 2, 8'd20, 3'd1, 1'b0, 4, 97, 0);    // stuck-at-1
        run(0, 0, 8'd0,  3'd0, 1'b1, 4, 97, 0);    // restart clears results

        // Reset mid-run with errors already accumulated
        mode = 1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (29) @(negedge clk);
        check("midrun_err_nonzero", 32'(err_v[0] != 8'd0), 32'd1);
        rst_v[0] = 1'b1;
        @(negedge clk);
        check_reset0("midrst");
        start_v[0] = 1'b1;                          // RST and START together: RST wins
        @(negedge clk);
        start_v[0] = 1'b0;
        rst_v[0] = 1'b0;
        check("rst_start_busy", 32'(busy_v[0]), 32'd0);
        repeat (120) @(negedge clk);
        check("idle_after_rst_busy", 32'(busy_v[0]), 32'd0);
        check("idle_after_rst_done", 32'(done_v[0]), 32'd0);

        run(1, 3, 8'd255, 3'd0, 1'b0, 40, 961, 0); // inverted, 320 misses saturate
        run(2, 0, 8'd0,   3'd0, 1'b1, 4,  65,  0); // glitch in unsampled cycle

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        summary();
    end

endmodule
